logic_tt_sweeper: RTL and testbench

//  Sequencer that drives the 3-input combinational logic stage (a,b,c -> out_sop,out_pos).

---
 rtl/logic_tt_sweeper_pkg.sv | 25 ++
 rtl/logic_tt_sweeper_if.sv | 34 +++
 rtl/logic_tt_sweeper.sv | 98 +++++++++
 tb/tb_logic_tt_sweeper.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_tt_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
`timescale 1ns/1ps
package logic_tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  // Response masks of the reference logic stage: sop = maj(a,b,c), pos = a|b|c.
  localparam logic [7:0] EXP_SOP_DEF = 8'hE8;
  localparam logic [7:0] EXP_POS_DEF = 8'hFE;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Wide enough to hold a count of TT_W itself.
  function automatic int cnt_width(input int n_in);
    return $clog2(tt_width(n_in)) + 1;
  endfunction

endpackage

// File: rtl/logic_tt_sweeper_if.sv
// Stimulus/response and result bundle between the sweeper and its controller.
`timescale 1ns/1ps
interface logic_tt_sweeper_if #(
  parameter int N_IN = 3
);
  import logic_tt_pkg::*;

  localparam int TT_W = tt_width(N_IN);
  localparam int CW   = cnt_width(N_IN);

  logic            start;
  logic            busy;
  logic [N_IN-1:0] vec_out;
  logic            sop_in;
  logic            pos_in;
  logic [TT_W-1:0] tt_sop;
  logic [TT_W-1:0] tt_pos;
  logic            done;
  logic            pass;
  logic [CW-1:0]   mismatch_cnt;

  // Controller and logic-stage side.
  modport master (
    output start, sop_in, pos_in,
    input  busy, vec_out, tt_sop, tt_pos, done, pass, mismatch_cnt
  );

  // Sweeper side.
  modport slave (
    input  start, sop_in, pos_in,
    output busy, vec_out, tt_sop, tt_pos, done, pass, mismatch_cnt
  );

endinterface

// File: rtl/logic_tt_sweeper.sv
// Sweeps every input vector of the logic stage, captures both outputs after a
// settle time, and compares the resulting truth tables against expected masks.
`timescale 1ns/1ps
module logic_tt_sweeper
  import logic_tt_pkg::*;
#(
  parameter int                    N_IN    = 3,
  parameter int                    SETTLE  = 1,
  parameter logic [(1<<N_IN)-1:0]  EXP_SOP = EXP_SOP_DEF,
  parameter logic [(1<<N_IN)-1:0]  EXP_POS = EXP_POS_DEF
) (
  input logic               clk,
  input logic               areset,
  logic_tt_sweeper_if.slave bus
);

  localparam int              TT_W     = tt_width(N_IN);
  localparam int              CW       = cnt_width(N_IN);
  localparam int              SW       = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);
  localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [SW-1:0]   settle_cnt;
  logic            hit;
  logic [CW-1:0]   mismatch_next;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    hit           = (bus.sop_in != EXP_SOP[idx]) || (bus.pos_in != EXP_POS[idx]);
    mismatch_next = bus.mismatch_cnt + CW'(hit);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state            <= IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      bus.busy         <= 1'b0;
      bus.vec_out      <= '0;
      bus.tt_sop       <= '0;
      bus.tt_pos       <= '0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.mismatch_cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            idx              <= '0;
            bus.vec_out      <= '0;
            bus.tt_sop       <= '0;
            bus.tt_pos       <= '0;
            bus.mismatch_cnt <= '0;
            bus.pass         <= 1'b0;
            settle_cnt       <= SETTLE_LOAD;
            bus.busy         <= 1'b1;
            state            <= WAIT;
          end
        end

        WAIT: begin
          if (settle_cnt == '0) state <= CAPTURE;
          else                  settle_cnt <= settle_cnt - SW'(1);
        end

        CAPTURE: begin
          bus.tt_sop[idx]  <= bus.sop_in;
          bus.tt_pos[idx]  <= bus.pos_in;
          bus.mismatch_cnt <= mismatch_next;
          if (idx != LAST_IDX) begin
            idx         <= idx + N_IN'(1);
            bus.vec_out <= idx + N_IN'(1);
            settle_cnt  <= SETTLE_LOAD;
            state       <= WAIT;
          end else begin
            // Pass is judged on the count including the final vector.
            bus.vec_out <= '0;
            bus.pass    <= (mismatch_next == '0);
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_tt_sweeper.sv
// Randomised and directed bench for logic_tt_sweeper, using a table-driven
// model of the logic stage and a truth-table-level reference for results.
`timescale 1ns/1ps
module tb_logic_tt_sweeper;
  import logic_tt_pkg::*;

  localparam int N_IN = 3;
  localparam int TT_W = 8;
  localparam int CW   = 4;

  logic clk    = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  logic_tt_sweeper_if #(.N_IN(N_IN)) if1 ();
  logic_tt_sweeper_if #(.N_IN(N_IN)) if3 ();

  logic_tt_sweeper #(.N_IN(N_IN), .SETTLE(1)) u_dut1 (.clk(clk), .areset(areset), .bus(if1));
  logic_tt_sweeper #(.N_IN(N_IN), .SETTLE(3)) u_dut3 (.clk(clk), .areset(areset), .bus(if3));

  // Logic stage models: a lookup table, optionally seen through a 2-cycle delay.
  logic [TT_W-1:0] sop_tab1 = EXP_SOP_DEF, pos_tab1 = EXP_POS_DEF;
  logic [TT_W-1:0] sop_tab3 = EXP_SOP_DEF, pos_tab3 = EXP_POS_DEF;
  bit              dly1 = 1'b0;
  logic [N_IN-1:0] d1a = '0, d1b = '0, d3a = '0, d3b = '0;

  always @(posedge clk) begin
    d1a <= if1.vec_out;
    d1b <= d1a;
    d3a <= if3.vec_out;
    d3b <= d3a;
  end

  assign if1.sop_in = sop_tab1[dly1 ? d1b : if1.vec_out];
  assign if1.pos_in = pos_tab1[dly1 ? d1b : if1.vec_out];
  assign if3.sop_in = sop_tab3[d3b];
  assign if3.pos_in = pos_tab3[d3b];

  bit              sel = 1'b0;
  logic            s_done, s_busy, s_pass;
  logic [N_IN-1:0] s_vec;
  logic [TT_W-1:0] s_tt_sop, s_tt_pos;
  logic [CW-1:0]   s_cnt;

  always_comb begin
    s_done   = sel ? if3.done         : if1.done;
    s_busy   = sel ? if3.busy         : if1.busy;
    s_pass   = sel ? if3.pass         : if1.pass;
    s_vec    = sel ? if3.vec_out      : if1.vec_out;
    s_tt_sop = sel ? if3.tt_sop       : if1.tt_sop;
    s_tt_pos = sel ? if3.tt_pos       : if1.tt_pos;
    s_cnt    = sel ? if3.mismatch_cnt : if1.mismatch_cnt;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Table the sweeper will actually observe: a delayed stage still shows the
  // previous vector's response when the hold time does not exceed its latency.
  function automatic logic [TT_W-1:0] seen_tab(input logic [TT_W-1:0] tab,
                                               input int settle, input int stage_lat);
    logic [TT_W-1:0] r;
    int src;
    for (int k = 0; k < TT_W; k++) begin
      if (settle + 1 > stage_lat) src = k;
      else                        src = (k == 0) ? 0 : k - 1;
      r[k] = tab[src];
    end
    return r;
  endfunction

  function automatic int ref_mismatch(input logic [TT_W-1:0] st, input logic [TT_W-1:0] pt);
    logic [TT_W-1:0] xs, xp;
    int n;
    xs = EXP_SOP_DEF;
    xp = EXP_POS_DEF;
    n  = 0;
    for (int k = 0; k < TT_W; k++)
      if (st[k] != xs[k] || pt[k] != xp[k]) n++;
    return n;
  endfunction

  // Samples #1 after each edge following E0; returns the edge count at done.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s_done && lat < 400);
  endtask

  task automatic run_sweep(input bit which, output int lat);
    sel = which;
    @(negedge clk);
    if (which) if3.start = 1'b1;
    else       if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    if3.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic check_sweep(input string tag, input int settle, input int lat,
                             input logic [TT_W-1:0] st, input logic [TT_W-1:0] pt,
                             input int stage_lat);
    logic [TT_W-1:0] es, ep;
    int n;
    es = seen_tab(st, settle, stage_lat);
    ep = seen_tab(pt, settle, stage_lat);
    n  = ref_mismatch(es, ep);
    check({tag, " done_edge"}, lat, TT_W * (settle + 1));
    check({tag, " tt_sop"}, s_tt_sop, es);
    check({tag, " tt_pos"}, s_tt_pos, ep);
    check({tag, " mismatch_cnt"}, s_cnt, n);
    check({tag, " pass"}, s_pass, (n == 0));
    check({tag, " busy_in_done"}, s_busy, 0);
    check({tag, " vec_out_in_done"}, s_vec, 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, s_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_at[$];
    int vec_seq[$];
    int busy_err;
    int n_done;
    logic [N_IN-1:0] prev_vec;

    if1.start = 1'b0;
    if3.start = 1'b0;

    // Reset state
    #2 areset = 1'b1;
    #1;
    check("reset busy", if1.busy, 0);
    check("reset done", if1.done, 0);
    check("reset pass", if1.pass, 0);
    check("reset vec_out", if1.vec_out, 0);
    check("reset tables", {if1.tt_sop, if1.tt_pos}, 0);
    check("reset mismatch_cnt", if1.mismatch_cnt, 0);
    @(negedge clk); areset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: correct stage
    run_sweep(0, lat);
    check_sweep("t1", 1, lat, sop_tab1, pos_tab1, 0);

    // 2: pos output stuck low
    pos_tab1 = '0;
    run_sweep(0, lat);
    check_sweep("t2", 1, lat, sop_tab1, pos_tab1, 0);
    pos_tab1 = EXP_POS_DEF;

    // 3: start held high across several sweeps
    sel = 1'b0;
    busy_err = 0;
    prev_vec = '0;
    @(negedge clk); if1.start = 1'b1;
    for (int n = 0; n <= 52; n++) begin
      @(posedge clk); #1;
      if (s_done) done_at.push_back(n);
      if (s_vec != prev_vec) vec_seq.push_back(int'(s_vec));
      prev_vec = s_vec;
      if (s_busy != ((n % 18) < 16)) busy_err++;
    end
    if1.start = 1'b0;
    check("t3 done_count", done_at.size(), 3);
    for (int i = 0; i < done_at.size(); i++)
      check($sformatf("t3 done_edge[%0d]", i), done_at[i], 16 + 18 * i);
    check("t3 vec_changes", vec_seq.size(), 24);
    for (int i = 0; i < vec_seq.size(); i++)
      check($sformatf("t3 vec_seq[%0d]", i), vec_seq[i], (i + 1) % TT_W);
    check("t3 busy_profile_errors", busy_err, 0);
    repeat (2) @(posedge clk);

    // 4: asynchronous reset mid-sweep
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 areset = 1'b1;
    #1;
    check("t4 busy_before_edge", if1.busy, 0);
    check("t4 vec_out", if1.vec_out, 0);
    check("t4 tables", {if1.tt_sop, if1.tt_pos}, 0);
    check("t4 mismatch_cnt", if1.mismatch_cnt, 0);
    check("t4 pass_done", {if1.pass, if1.done}, 0);
    @(negedge clk); areset = 1'b0;
    n_done = 0;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      if (if1.done) n_done++;
    end
    check("t4 no_done_after_abort", n_done, 0);
    run_sweep(0, lat);
    check_sweep("t4r", 1, lat, sop_tab1, pos_tab1, 0);

    // 5: delayed stage with long and short settle
    run_sweep(1, lat);
    check_sweep("t5a", 3, lat, sop_tab3, pos_tab3, 2);
    dly1 = 1'b1;
    run_sweep(0, lat);
    check_sweep("t5b", 1, lat, sop_tab1, pos_tab1, 2);
    dly1 = 1'b0;

    // 6: back-to-back, failing then correct stage
    sop_tab1 = ~EXP_SOP_DEF;
    run_sweep(0, lat);
    check_sweep("t6a", 1, lat, sop_tab1, pos_tab1, 0);
    sop_tab1 = EXP_SOP_DEF;
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    check("t6 cleared_tables", {if1.tt_sop, if1.tt_pos}, 0);
    check("t6 cleared_cnt", if1.mismatch_cnt, 0);
    check("t6 cleared_pass", if1.pass, 0);
    check("t6 busy_after_accept", if1.busy, 1);
    wait_done(lat);
    check_sweep("t6b", 1, lat, sop_tab1, pos_tab1, 0);

    // Randomised stage tables on both instances
    for (int it = 0; it < 8; it++) begin
      bit which;
      which = 1'($urandom_range(0, 1));
      if (which) begin
        sop_tab3 = EXP_SOP_DEF ^ (TT_W'(1) << $urandom_range(0, TT_W - 1));
        pos_tab3 = (it % 2 == 0) ? EXP_POS_DEF : TT_W'($urandom);
        run_sweep(1, lat);
        check_sweep($sformatf("rnd%0d_s3", it), 3, lat, sop_tab3, pos_tab3, 2);
      end else begin
        sop_tab1 = (it % 2 == 0) ? TT_W'($urandom) : EXP_SOP_DEF;
        pos_tab1 = EXP_POS_DEF ^ (TT_W'(1) << $urandom_range(0, TT_W - 1));
        dly1     = 1'($urandom_range(0, 1));
        run_sweep(0, lat);
        check_sweep($sformatf("rnd%0d_s1", it), 1, lat, sop_tab1, pos_tab1, dly1 ? 2 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
